// File: rtl/scytale_codec_if.sv
// scytale_codec_if: character input, key/mode sideband and valid/ready output channel
interface scytale_codec_if #(parameter int D_WIDTH = 8, parameter int KEY_WIDTH = 8);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic                 mode_i;
  logic [KEY_WIDTH-1:0] key_N;
  logic [KEY_WIDTH-1:0] key_M;
  logic                 busy_o;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 err_o;
  modport master (output data_i, valid_i, mode_i, key_N, key_M, ready_i,
                  input  busy_o, data_o, valid_o, err_o);
  modport slave  (input  data_i, valid_i, mode_i, key_N, key_M, ready_i,
                  output busy_o, data_o, valid_o, err_o);
endinterface

// File: rtl/scytale_codec.sv
// scytale_codec: buffers a message until the token, then emits it scytale-decrypted or encrypted
module scytale_codec #(
  parameter int D_WIDTH = 8,
  parameter int KEY_WIDTH = 8,
  parameter int MAX_NOF_CHARS = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
  input logic clk,
  input logic rst,
  scytale_codec_if.slave bus
);
  localparam int PW = $clog2(MAX_NOF_CHARS);
  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int KW = KEY_WIDTH;
  localparam logic [CW-1:0] MAXC = CW'(MAX_NOF_CHARS);
  typedef enum logic {LOAD, EMIT} state_t;
  state_t r_state, w_next;
  logic [D_WIDTH-1:0] r_buf [MAX_NOF_CHARS];
  logic [CW-1:0] r_count, r_t;
  logic r_ovf, r_err, r_mode;
  logic [KW-1:0] r_n, r_m, r_inner, r_outer;
  logic [PW-1:0] r_ptr;
  logic [2*KW-1:0] w_len;
  logic [KW-1:0] w_stride, w_lim;
  logic w_chr, w_tok, w_ok, w_xfer, w_last, w_wrap;
  assign w_chr = r_state == LOAD && bus.valid_i && bus.data_i != START_DECRYPTION_TOKEN;
  assign w_tok = r_state == LOAD && bus.valid_i && bus.data_i == START_DECRYPTION_TOKEN;
  assign w_len = (2*KW)'(bus.key_N) * (2*KW)'(bus.key_M);
  assign w_ok = !r_ovf && |bus.key_N && |bus.key_M && w_len == (2*KW)'(r_count);
  // decrypt walks columns with stride N over M rows; encrypt is the transpose
  assign w_stride = r_mode ? r_m : r_n;
  assign w_lim = r_mode ? r_n : r_m;
  assign w_xfer = r_state == EMIT && bus.ready_i;
  assign w_last = r_t == r_count - 1'b1;
  assign w_wrap = r_inner == w_lim - 1'b1;
  always_comb begin
    w_next = r_state == LOAD ? (w_tok && w_ok ? EMIT : LOAD) : (w_xfer && w_last ? LOAD : EMIT);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (w_chr && r_count < MAXC) r_buf[r_count] <= bus.data_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_chr) begin
        if (r_count < MAXC) r_count <= r_count + 1'b1;
        else r_ovf <= 1'b1;
      end
      if (w_tok) begin
        r_n <= bus.key_N;
        r_m <= bus.key_M;
        r_mode <= bus.mode_i;
        r_ptr <= '0;
        r_inner <= '0;
        r_outer <= '0;
        r_t <= '0;
        if (!w_ok) begin
          r_err <= 1'b1;
          r_count <= '0;
          r_ovf <= 1'b0;
        end
      end
      if (w_xfer) begin
        r_t <= r_t + 1'b1;
        r_inner <= w_wrap ? '0 : r_inner + 1'b1;
        r_outer <= w_wrap ? r_outer + 1'b1 : r_outer;
        r_ptr <= w_wrap ? PW'(r_outer + 1'b1) : r_ptr + PW'(w_stride);
        if (w_last) begin
          r_count <= '0;
          r_ovf <= 1'b0;
        end
      end
    end
  end
  assign bus.busy_o = r_state == EMIT;
  assign bus.valid_o = r_state == EMIT;
  assign bus.data_o = r_state == EMIT ? r_buf[r_ptr] : '0;
  assign bus.err_o = r_err;
endmodule
